mobo_mem_ctrl: RTL



---
 rtl/mobo_mem_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mobo_mem_ctrl.sv
// mobo_mem_ctrl: motherboard-side bus controller between the cpu core and an
// internal word-addressed RAM. It runs one transaction at a time through
// IDLE -> WAIT (WAIT_CYCLES cycles) -> ACCESS -> DONE.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-high
//   mobo_ctrl  command word: [0] read, [1] write, 2'b11 is an illegal op
//   addr       word address (index = addr[ADDR_BITS-1:0])
//   wr_data    write data
//   mobo_stat  status word: [0] busy, [1] done pulse, [2] err (valid with done)
//   rd_data    registered read data, held until the next read completes
//
// Optional feature: define MOBO_RANGE_CHECK_EN to flag addresses >= MEM_WORDS
// as errors. Such an access leaves the RAM untouched and returns 0 on a read.
// Without the macro, upper address bits are ignored and the index wraps.
module mobo_mem_ctrl #(
  parameter int word_width  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] wr_data,
  output logic [word_width-1:0] mobo_stat,
  output logic [word_width-1:0] rd_data
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]            op;
    logic [word_width-1:0] addr;
    logic [word_width-1:0] data;
  } req_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt;
  req_t                  req;
  logic                  err_q;
  logic                  accept, fire;
  logic [ADDR_BITS-1:0]  idx;
  logic                  is_rd, is_wr, illegal, oor, err_c;
  logic [word_width-1:0] mem [MEM_WORDS];

  assign idx     = req.addr[ADDR_BITS-1:0];
  assign is_rd   = (req.op == 2'b01);
  assign is_wr   = (req.op == 2'b10);
  assign illegal = (req.op == 2'b11);

`ifdef MOBO_RANGE_CHECK_EN
  assign oor = (req.addr >= word_width'(MEM_WORDS));
`else
  assign oor = 1'b0;
`endif

  assign err_c = illegal | oor;

  // Command bits above [1:0] and address bits above the index are don't-care.
  logic unused_bits;
  assign unused_bits = ^{mobo_ctrl[word_width-1:2], req.addr[word_width-1:ADDR_BITS]};

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mobo_ctrl[1:0] != 2'b00) begin
          accept   = 1'b1;
          state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        fire     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      req     <= '0;
      err_q   <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req <= '{op: mobo_ctrl[1:0], addr: addr, data: wr_data};
        cnt <= CNT_W'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (fire) begin
        err_q <= err_c;
        // Illegal ops leave rd_data alone; out-of-range reads return zero.
        if (is_rd) rd_data <= oor ? '0 : mem[idx];
      end
    end
  end

  // RAM has no reset; a write on the same edge as rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && fire && is_wr && !oor) mem[idx] <= req.data;
  end

  assign mobo_stat = {{(word_width-3){1'b0}},
                      (state == S_DONE) & err_q,
                      (state == S_DONE),
                      (state == S_WAIT) || (state == S_ACCESS)};

endmodule
